fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter INSTR_W, default 16, instruction word width in bits.
REQ-002 SHALL have parameter PC_W, default 32, program-counter width in bits.
REQ-003 SHALL have parameter MEM_AW, default 20, instruction-memory address width; depth 2**MEM_AW words.
REQ-004 SHALL have parameter RESET_PC, default 32, first instruction address; entries 0..RESET_PC-1 are the interrupt vector table.
REQ-005 SHALL have parameter NOP_WORD, default 'hA000, word issued when no valid instruction is presented.
REQ-006 SHALL have parameter IMM_BIT, default 0, instruction bit that marks a two-word (immediate) instruction.
REQ-007 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port stall, input, 1, hold PC and outputs when high.
REQ-010 SHALL have port redirect, input, 1, branch/jump taken this cycle.
REQ-011 SHALL have port redirect_pc, input, PC_W, branch target.
REQ-012 SHALL have port int_req, input, 1, interrupt request, level-sensitive.
REQ-013 SHALL have port int_idx, input, 5, vector-table index.
REQ-014 SHALL have port instruction, output, INSTR_W, fetched word or NOP_WORD.
REQ-015 SHALL have port instr_valid, output, 1, instruction holds a real fetched word.
REQ-016 SHALL have port is_imm, output, 1, instruction is the second (immediate) word.
REQ-017 SHALL have port pc_out, output, PC_W, address of the word on instruction.
REQ-018 SHALL have port ret_pc, output, PC_W, return address captured on interrupt entry.
REQ-019 SHALL have port int_ack, output, 1, one-cycle pulse when the vector is taken.

Function
REQ-020 SHALL use FSM states RUN, IMM, VEC; memory read combinational at mem[PC[MEM_AW-1:0]].
REQ-021 SHALL, per cycle, apply priority: redirect > stall > int_req > normal advance.
REQ-022 SHALL in RUN present mem[PC] with instr_valid=1, PC<=PC+1; if that word's IMM_BIT=1, next state IMM.
REQ-023 SHALL in IMM present mem[PC] with instr_valid=1, is_imm=1, PC<=PC+1, next state RUN.
REQ-024 SHALL take int_req only in RUN at an instruction boundary (never between a word and its immediate): instruction=NOP_WORD, instr_valid=0, ret_pc<=PC, next state VEC.
REQ-025 SHALL in VEC load PC<=zero-extended mem[int_idx], pulse int_ack=1, present NOP_WORD with instr_valid=0, next state RUN.
REQ-026 SHALL on redirect in any state load PC<=redirect_pc, present NOP_WORD with instr_valid=0, state RUN; a pending IMM or VEC is abandoned.
REQ-027 SHALL on stall (without redirect) hold PC, state, ret_pc; present NOP_WORD, instr_valid=0, int_ack=0.
REQ-028 SHALL wrap PC modulo 2**PC_W; memory index uses PC low MEM_AW bits only.
REQ-029 SHALL drive pc_out = current PC in every cycle.

Reset
REQ-030 SHALL on reset asynchronously set PC=RESET_PC, state=RUN, ret_pc=0, int_ack=0.
REQ-031 SHALL, while reset is high, present instruction=NOP_WORD, instr_valid=0, is_imm=0.
REQ-032 SHALL resume fetching mem[RESET_PC] on the first posedge after reset deasserts; reset mid-IMM or mid-VEC discards that operation.

Structure
REQ-033 SHALL take FSM state encoding and NOP_WORD default from shared package fetch_pkg.
REQ-034 SHALL contain one sub-module pc_next computing next PC from state, redirect, stall, vector and IMM flag; memory array stays in fetch_unit.

Verification
REQ-035 SHALL check reset: mem[32]=16'h1234 -> after release, instruction=16'h1234, instr_valid=1, pc_out=32.
REQ-036 SHALL check immediate: mem[32]=16'h0001, mem[33]=16'hBEEF, int_req high -> word 33 is_imm=1, interrupt deferred to the following cycle, ret_pc=34.
REQ-037 SHALL check interrupt: int_idx=3, mem[3]=16'h0100 at PC=40 -> one NOP, int_ack pulse, ret_pc=40, next fetch pc_out=256.
REQ-038 SHALL check redirect beats stall: stall=1, redirect=1, redirect_pc=500 -> NOP, next cycle pc_out=500.
REQ-039 SHALL check stall: stall held 3 cycles at PC=50 -> pc_out=50 throughout, instr_valid=0, fetch resumes at 50.
REQ-040 SHALL check wrap: PC_W=8, redirect_pc=255 -> next fetch pc_out=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch unit: FSM encoding and the default NOP word.
package fetch_pkg;
    localparam logic [1:0] ST_RUN = 2'd0;
    localparam logic [1:0] ST_IMM = 2'd1;
    localparam logic [1:0] ST_VEC = 2'd2;

    localparam logic [15:0] NOP_DEFAULT = 16'hA000;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: control inputs, fetched-word outputs, and a program-load write port.
interface fetch_unit_if #(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 32,
    parameter int MEM_AW  = 20
);
    logic               stall;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               int_req;
    logic [4:0]         int_idx;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic               is_imm;
    logic [PC_W-1:0]    pc_out;
    logic [PC_W-1:0]    ret_pc;
    logic               int_ack;
    logic               prog_we;
    logic [MEM_AW-1:0]  prog_addr;
    logic [INSTR_W-1:0] prog_data;

    modport master (
        output stall, redirect, redirect_pc, int_req, int_idx,
               prog_we, prog_addr, prog_data,
        input  instruction, instr_valid, is_imm, pc_out, ret_pc, int_ack
    );
    modport slave (
        input  stall, redirect, redirect_pc, int_req, int_idx,
               prog_we, prog_addr, prog_data,
        output instruction, instr_valid, is_imm, pc_out, ret_pc, int_ack
    );
endinterface

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection: redirect beats stall beats interrupt entry beats sequential advance.
module pc_next
    import fetch_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [1:0]      state_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    input  logic            stall_i,
    input  logic            int_req_i,
    input  logic [PC_W-1:0] vec_pc_i,
    output logic [PC_W-1:0] pc_d_o
);
    always_comb begin
        pc_d_o = pc_i;
        if (redirect_i) begin
            pc_d_o = redirect_pc_i;
        end else if (!stall_i) begin
            case (state_i)
                // Interrupt entry holds PC so it can be captured as the return address.
                ST_RUN:  pc_d_o = int_req_i ? pc_i : pc_i + PC_W'(1);
                ST_IMM:  pc_d_o = pc_i + PC_W'(1);
                ST_VEC:  pc_d_o = vec_pc_i;
                default: pc_d_o = pc_i;
            endcase
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: combinational-read instruction memory, two-word immediates, vectored interrupts.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                 INSTR_W  = 16,
    parameter int                 PC_W     = 32,
    parameter int                 MEM_AW   = 20,
    parameter int                 RESET_PC = 32,
    parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(NOP_DEFAULT),
    parameter int                 IMM_BIT  = 0
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.slave  bus
);
    logic [INSTR_W-1:0] mem [2**MEM_AW];

    logic [1:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    ret_pc_q, ret_pc_d;
    logic [INSTR_W-1:0] fetch_word;
    logic [PC_W-1:0]    vec_pc;

    always_ff @(posedge clk) begin
        if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
    end

    assign fetch_word = mem[MEM_AW'(pc_q)];
    assign vec_pc     = PC_W'(mem[MEM_AW'(bus.int_idx)]);

    pc_next #(.PC_W(PC_W)) u_pc_next (
        .state_i       (state_q),
        .pc_i          (pc_q),
        .redirect_i    (bus.redirect),
        .redirect_pc_i (bus.redirect_pc),
        .stall_i       (bus.stall),
        .int_req_i     (bus.int_req),
        .vec_pc_i      (vec_pc),
        .pc_d_o        (pc_d)
    );

    always_comb begin
        state_d         = state_q;
        ret_pc_d        = ret_pc_q;
        bus.instruction = NOP_WORD;
        bus.instr_valid = 1'b0;
        bus.is_imm      = 1'b0;
        bus.int_ack     = 1'b0;
        if (bus.redirect) begin
            state_d = ST_RUN;
        end else if (!bus.stall) begin
            case (state_q)
                ST_RUN: begin
                    if (bus.int_req) begin
                        ret_pc_d = pc_q;
                        state_d  = ST_VEC;
                    end else begin
                        bus.instruction = fetch_word;
                        bus.instr_valid = 1'b1;
                        if (fetch_word[IMM_BIT]) state_d = ST_IMM;
                    end
                end
                ST_IMM: begin
                    bus.instruction = fetch_word;
                    bus.instr_valid = 1'b1;
                    bus.is_imm      = 1'b1;
                    state_d         = ST_RUN;
                end
                ST_VEC: begin
                    bus.int_ack = 1'b1;
                    state_d     = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
        // State still reads RUN during reset, so the outputs must be forced quiet.
        if (reset) begin
            bus.instruction = NOP_WORD;
            bus.instr_valid = 1'b0;
            bus.is_imm      = 1'b0;
            bus.int_ack     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            pc_q     <= PC_W'(RESET_PC);
            ret_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ret_pc_q <= ret_pc_d;
        end
    end

    assign bus.pc_out = pc_q;
    assign bus.ret_pc = ret_pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, immediates, interrupts, redirect/stall priority, PC wrap.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.INSTR_W(16), .PC_W(32), .MEM_AW(20)) b ();
    fetch_unit_if #(.INSTR_W(16), .PC_W(8),  .MEM_AW(8))  b8 ();

    fetch_unit u_dut (.clk(clk), .reset(reset), .bus(b.slave));
    fetch_unit #(.PC_W(8), .MEM_AW(8)) u_dut8 (.clk(clk), .reset(reset), .bus(b8.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [19:0] a, input logic [15:0] d);
        b.prog_we = 1'b1; b.prog_addr = a; b.prog_data = d;
        step();
        b.prog_we = 1'b0;
    endtask

    task automatic prog8(input logic [7:0] a, input logic [15:0] d);
        b8.prog_we = 1'b1; b8.prog_addr = a; b8.prog_data = d;
        step();
        b8.prog_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        b.stall = 0; b.redirect = 0; b.redirect_pc = '0; b.int_req = 0; b.int_idx = '0;
        b.prog_we = 0; b.prog_addr = '0; b.prog_data = '0;
        b8.stall = 0; b8.redirect = 0; b8.redirect_pc = '0; b8.int_req = 0; b8.int_idx = '0;
        b8.prog_we = 0; b8.prog_addr = '0; b8.prog_data = '0;

        // reset release fetches mem[32]
        prog(20'd32, 16'h1234);
        #1;
        chk("rst_instr", 32'(b.instruction), 32'hA000);
        chk("rst_valid", 32'(b.instr_valid), 0);
        chk("rst_imm",   32'(b.is_imm), 0);
        chk("rst_pc",    b.pc_out, 32);
        chk("rst_retpc", b.ret_pc, 0);
        chk("rst_ack",   32'(b.int_ack), 0);
        reset = 1'b0; #1;
        chk("first_instr", 32'(b.instruction), 32'h1234);
        chk("first_valid", 32'(b.instr_valid), 1);
        chk("first_pc",    b.pc_out, 32);

        // immediate pair with interrupt arriving on the second word
        reset = 1'b1; #1;
        prog(20'd32, 16'h0001);
        prog(20'd33, 16'hBEEF);
        prog(20'd34, 16'h0002);
        prog(20'd3,  16'h0100);
        prog(20'd256, 16'h0002);
        prog(20'd40, 16'h0004);
        prog(20'd500, 16'h0006);
        prog(20'd50, 16'h0008);
        prog(20'd51, 16'h000A);
        prog8(8'd255, 16'h0002);
        prog8(8'd0,   16'h0004);
        reset = 1'b0; #1;
        chk("imm_w0", 32'(b.instruction), 32'h0001);
        chk("imm_w0_isimm", 32'(b.is_imm), 0);
        step();
        b.int_req = 1; b.int_idx = 5'd3; #1;
        chk("imm_w1", 32'(b.instruction), 32'hBEEF);
        chk("imm_w1_isimm", 32'(b.is_imm), 1);
        chk("imm_w1_valid", 32'(b.instr_valid), 1);
        chk("imm_w1_pc", b.pc_out, 33);
        step();
        chk("int_defer_pc", b.pc_out, 34);
        chk("int_defer_valid", 32'(b.instr_valid), 0);
        chk("int_defer_nop", 32'(b.instruction), 32'hA000);
        step();
        b.int_req = 0; #1;
        chk("imm_vec_ack", 32'(b.int_ack), 1);
        chk("imm_retpc", b.ret_pc, 34);
        step();
        chk("imm_vec_pc", b.pc_out, 256);
        chk("imm_vec_ack_off", 32'(b.int_ack), 0);

        // interrupt at PC=40
        b.redirect = 1; b.redirect_pc = 32'd40; #1;
        chk("redir40_nop", 32'(b.instr_valid), 0);
        step();
        b.redirect = 0; b.int_req = 1; b.int_idx = 5'd3; #1;
        chk("int40_pc", b.pc_out, 40);
        chk("int40_nop", 32'(b.instruction), 32'hA000);
        chk("int40_valid", 32'(b.instr_valid), 0);
        step();
        b.int_req = 0; #1;
        chk("int40_ack", 32'(b.int_ack), 1);
        chk("int40_retpc", b.ret_pc, 40);
        chk("int40_vec_nop", 32'(b.instr_valid), 0);
        step();
        chk("int40_target", b.pc_out, 256);
        chk("int40_target_instr", 32'(b.instruction), 32'h0002);
        chk("int40_ack_off", 32'(b.int_ack), 0);

        // redirect beats stall
        b.stall = 1; b.redirect = 1; b.redirect_pc = 32'd500; #1;
        chk("rvs_nop", 32'(b.instruction), 32'hA000);
        chk("rvs_valid", 32'(b.instr_valid), 0);
        step();
        b.stall = 0; b.redirect = 0; #1;
        chk("rvs_pc", b.pc_out, 500);
        chk("rvs_instr", 32'(b.instruction), 32'h0006);

        // three-cycle stall at PC=50
        b.redirect = 1; b.redirect_pc = 32'd50;
        step();
        b.redirect = 0; b.stall = 1; #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_pc", b.pc_out, 50);
            chk("stall_valid", 32'(b.instr_valid), 0);
            if (i < 2) step();
        end
        step();
        b.stall = 0; #1;
        chk("stall_resume_pc", b.pc_out, 50);
        chk("stall_resume_instr", 32'(b.instruction), 32'h0008);
        step();
        chk("stall_next_pc", b.pc_out, 51);

        // 8-bit PC wraps 255 -> 0
        b8.redirect = 1; b8.redirect_pc = 8'd255;
        step();
        b8.redirect = 0; #1;
        chk("wrap_pc255", 32'(b8.pc_out), 255);
        chk("wrap_instr255", 32'(b8.instruction), 32'h0002);
        step();
        chk("wrap_pc0", 32'(b8.pc_out), 0);
        chk("wrap_instr0", 32'(b8.instruction), 32'h0004);

        // reset in mid-VEC discards the vector
        b.int_req = 1; b.int_idx = 5'd3;
        step();
        b.int_req = 0; #1;
        chk("vec_before_rst", 32'(b.int_ack), 1);
        reset = 1'b1; #1;
        chk("vec_rst_ack", 32'(b.int_ack), 0);
        chk("vec_rst_pc", b.pc_out, 32);
        step();
        reset = 1'b0; #1;
        chk("vec_rst_resume", 32'(b.instruction), 32'h0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
